ifu_fetch: RTL and testbench

IFU_FETCH -- requirements
Module: ifu_fetch

---
 rtl/ifu_fetch.sv | 105 ++++++++++
 tb/tb_ifu_fetch.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/ifu_fetch.sv
// rtl/ifu_fetch.sv - instruction fetch sequencer: PC, Icache request, stall hold, redirect drop
// Optional IFU_MISALIGN_TRAP_EN: reject misaligned redirect targets and flag them on if_misalign_o.
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fc_stall_if_i,
  input  logic        ex_branch_flag_i,
  input  logic [31:0] ex_branch_pc_i,
  input  logic        id_jump_flag_i,
  input  logic [31:0] id_jump_pc_i,
  input  logic        Icache_ready_i,
  output logic        if_req_o,
  output logic [31:0] if_addr_o,
  output logic [31:0] if_pc_o,
  output logic        if_valid_o,
  output logic        if_misalign_o
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD, DROP} state_t;

  state_t      state, state_nxt;
  logic [31:0] fetch_pc, fetch_pc_nxt;
  logic [31:0] held_pc, held_pc_nxt;
  logic [31:0] drop_pc, drop_pc_nxt;
  logic        redirect;
  logic        take;
  logic [31:0] raw_target;
  logic [31:0] target;

  assign redirect   = ex_branch_flag_i | id_jump_flag_i;
  assign raw_target = ex_branch_flag_i ? ex_branch_pc_i : id_jump_pc_i;

`ifdef IFU_MISALIGN_TRAP_EN
  assign target        = raw_target;
  assign take          = redirect && (raw_target[1:0] == 2'b00);
  assign if_misalign_o = redirect && !take && (state != IDLE);
`else
  assign target        = raw_target & 32'hFFFF_FFFC;
  assign take          = redirect;
  assign if_misalign_o = 1'b0;
`endif

  assign if_addr_o = fetch_pc;
  assign if_pc_o   = (state == HOLD) ? held_pc : fetch_pc;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      held_pc  <= RESET_PC;
      drop_pc  <= 32'h0;
    end else begin
      state    <= state_nxt;
      fetch_pc <= fetch_pc_nxt;
      held_pc  <= held_pc_nxt;
      drop_pc  <= drop_pc_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    fetch_pc_nxt = fetch_pc;
    held_pc_nxt  = held_pc;
    drop_pc_nxt  = drop_pc;
    if_req_o     = 1'b0;
    if_valid_o   = 1'b0;
    case (state)
      IDLE: state_nxt = FETCH;
      FETCH: begin
        if_req_o = 1'b1;
        if (take && Icache_ready_i) begin
          fetch_pc_nxt = target;
        end else if (take) begin
          drop_pc_nxt = target;
          state_nxt   = DROP;
        end else if (Icache_ready_i) begin
          if_valid_o   = 1'b1;
          held_pc_nxt  = fetch_pc;
          fetch_pc_nxt = fetch_pc + 32'd4;
          if (fc_stall_if_i) state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (take) begin
          fetch_pc_nxt = target;
          state_nxt    = FETCH;
        end else if (!fc_stall_if_i) begin
          state_nxt = FETCH;
        end
      end
      DROP: begin
        // The stale response still has to arrive before the new target can be requested.
        if (take) drop_pc_nxt = target;
        if (Icache_ready_i) begin
          fetch_pc_nxt = take ? target : drop_pc;
          state_nxt    = FETCH;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ifu_fetch.sv
// tb/tb_ifu_fetch.sv - directed and randomized checks of ifu_fetch against a transaction-level model
module tb_ifu_fetch;
  logic        clk;
  logic        rst_n;
  logic        stall, br, jf, rdy;
  logic [31:0] brpc, jpc;
  logic        req, valid, mis;
  logic [31:0] addr, pc;

  int n_pass = 0;
  int n_total = 0;

  // model: fetch lifecycle as flags plus addresses
  bit          m_started, m_hold, m_drop;
  logic [31:0] m_pc, m_shown, m_tgt;
  bit          m_ok;
  logic [31:0] m_tt;

  ifu_fetch #(.RESET_PC(32'h0)) dut (
    .clk(clk), .rst_n(rst_n), .fc_stall_if_i(stall),
    .ex_branch_flag_i(br), .ex_branch_pc_i(brpc),
    .id_jump_flag_i(jf), .id_jump_pc_i(jpc),
    .Icache_ready_i(rdy), .if_req_o(req), .if_addr_o(addr),
    .if_pc_o(pc), .if_valid_o(valid), .if_misalign_o(mis)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic m_reset();
    m_started = 0; m_hold = 0; m_drop = 0;
    m_pc = 32'h0; m_shown = 32'h0; m_tgt = 32'h0;
  endtask

  task automatic cmp();
    logic [31:0] t;
    bit red, e_req, e_val, e_mis;
    logic [31:0] e_pc;
    red = br | jf;
    t = br ? brpc : jpc;
`ifdef IFU_MISALIGN_TRAP_EN
    m_ok = red && (t % 4 == 0);
    m_tt = t;
`else
    m_ok = red;
    m_tt = t - (t % 4);
`endif
    e_req = m_started && !m_hold && !m_drop;
    e_val = e_req && rdy && !m_ok;
    e_pc  = m_hold ? m_shown : m_pc;
    e_mis = m_started && red && !m_ok;
    chk("req", {31'b0, req}, {31'b0, e_req});
    chk("valid", {31'b0, valid}, {31'b0, e_val});
    chk("pc", pc, e_pc);
    chk("misalign", {31'b0, mis}, {31'b0, e_mis});
    if (e_req) chk("addr", addr, m_pc);
  endtask

  task automatic adv();
    if (!rst_n) m_reset();
    else if (!m_started) m_started = 1;
    else if (m_drop) begin
      if (m_ok) m_tgt = m_tt;
      if (rdy) begin m_drop = 0; m_pc = m_tgt; end
    end else if (m_hold) begin
      if (m_ok) begin m_hold = 0; m_pc = m_tt; end
      else if (!stall) m_hold = 0;
    end else begin
      if (m_ok && rdy) m_pc = m_tt;
      else if (m_ok) begin m_tgt = m_tt; m_drop = 1; end
      else if (rdy) begin m_shown = m_pc; m_pc = m_pc + 32'd4; m_hold = stall; end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic s, input logic b, input logic [31:0] bp,
                       input logic j, input logic [31:0] jp, input logic rd);
    rst_n = r; stall = s; br = b; brpc = bp; jf = j; jpc = jp; rdy = rd;
    #3;
    cmp();
  endtask

  task automatic cyc(input logic s, input logic rd);
    drive(1, s, 0, 0, 0, 0, rd);
    adv();
  endtask

  initial begin
    rst_n = 0; stall = 0; br = 0; jf = 0; rdy = 0; brpc = 0; jpc = 0;
    m_reset();
    @(posedge clk);
    #1;
    chk("rst_req", {31'b0, req}, 32'h0);
    chk("rst_valid", {31'b0, valid}, 32'h0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_mis", {31'b0, mis}, 32'h0);

    cyc(0, 1);
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 0, 0, 0, 1);
      chk("seq_addr", addr, 32'(i * 4));
      chk("seq_valid", {31'b0, valid}, 32'h1);
      adv();
    end
    cyc(0, 1);
    drive(1, 1, 0, 0, 0, 0, 1); chk("stall_addr", addr, 32'h10); adv();
    drive(1, 1, 0, 0, 0, 0, 1); chk("hold_pc", pc, 32'h10); chk("hold_req", {31'b0, req}, 32'h0); adv();
    drive(1, 0, 0, 0, 0, 0, 0); chk("hold_release_req", {31'b0, req}, 32'h0); adv();
    drive(1, 0, 0, 0, 0, 0, 1); chk("after_hold_addr", addr, 32'h14); adv();
    cyc(0, 1); cyc(0, 1);
    drive(1, 0, 0, 0, 1, 32'h100, 0); chk("jump_addr", addr, 32'h20); adv();
    drive(1, 0, 0, 0, 0, 0, 0); chk("drop_req", {31'b0, req}, 32'h0); adv();
    drive(1, 0, 0, 0, 0, 0, 1); chk("drop_valid", {31'b0, valid}, 32'h0); adv();
    drive(1, 0, 0, 0, 0, 0, 0); chk("drop_target", addr, 32'h100); adv();
    drive(1, 0, 1, 32'h200, 1, 32'h300, 1); chk("prio_valid", {31'b0, valid}, 32'h0); adv();
    drive(1, 0, 0, 0, 1, 32'h40, 1); chk("prio_addr", addr, 32'h200); adv();
    drive(1, 0, 0, 0, 0, 0, 0); chk("mid_addr", addr, 32'h40); adv();
    drive(0, 0, 0, 0, 0, 0, 0); adv();
    drive(1, 0, 0, 0, 0, 0, 1); chk("rst2_req", {31'b0, req}, 32'h0); chk("rst2_pc", pc, 32'h0); adv();
    drive(1, 0, 0, 0, 0, 0, 1); chk("refetch_addr", addr, 32'h0); adv();
    drive(1, 0, 0, 0, 1, 32'h102, 1);
`ifdef IFU_MISALIGN_TRAP_EN
    chk("mis_pulse", {31'b0, mis}, 32'h1); adv();
    drive(1, 0, 0, 0, 0, 0, 0); chk("mis_seq_addr", addr, 32'h8); chk("mis_clear", {31'b0, mis}, 32'h0); adv();
`else
    chk("mis_tied", {31'b0, mis}, 32'h0); adv();
    drive(1, 0, 0, 0, 0, 0, 0); chk("align_addr", addr, 32'h100); adv();
`endif
    drive(1, 0, 0, 0, 1, 32'hFFFF_FFFC, 1); adv();
    drive(1, 0, 0, 0, 0, 0, 1); chk("top_addr", addr, 32'hFFFF_FFFC); adv();
    drive(1, 0, 0, 0, 0, 0, 0); chk("wrap_addr", addr, 32'h0); adv();

    for (int i = 0; i < 400; i++) begin
      logic [31:0] bt, jt;
      bt = $urandom; jt = $urandom;
      if ($urandom_range(99) < 60) bt[1:0] = 2'b00;
      if ($urandom_range(99) < 60) jt[1:0] = 2'b00;
      drive(($urandom_range(99) >= 2), ($urandom_range(99) < 30),
            ($urandom_range(99) < 10), bt, ($urandom_range(99) < 10), jt,
            ($urandom_range(99) < 50));
      adv();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
